// File: rtl/servo_pwm_mc_if.sv
// Command and pulse-pin bundle between the navigation controller and servo_pwm_mc.
// master drives commands and observes pins; slave is the PWM engine.
interface servo_pwm_mc_if #(
  parameter int NUM_CH  = 2,
  parameter int LEVEL_W = 5,
  parameter int SLOT_W  = 5
);
  logic [2*NUM_CH-1:0]       Cmd_Dir;
  logic [LEVEL_W*NUM_CH-1:0] Cmd_Level;
  logic                      Cmd_Valid;
  logic [NUM_CH-1:0]         Pulse_Out;
  logic                      Frame_Start;
  logic [SLOT_W-1:0]         Slot;
  logic                      Wdog_Trip;

  modport master (
    output Cmd_Dir, Cmd_Level, Cmd_Valid,
    input  Pulse_Out, Frame_Start, Slot, Wdog_Trip
  );

  modport slave (
    input  Cmd_Dir, Cmd_Level, Cmd_Valid,
    output Pulse_Out, Frame_Start, Slot, Wdog_Trip
  );
endinterface

// File: rtl/servo_pwm_mc.sv
// Multi-channel RC servo/ESC pulse generator with frame-skipping power control,
// frame-aligned command update and a neutral-forcing command watchdog.
module servo_pwm_mc #(
  parameter int NUM_CH         = 2,
  parameter int FRAME_CYC      = 2000000,
  parameter int FWD_CYC        = 100000,
  parameter int NEU_CYC        = 150000,
  parameter int REV_CYC        = 200000,
  parameter int SLOTS          = 24,
  parameter int LEVEL_W        = 5,
  parameter int TIMEOUT_FRAMES = 50
) (
  input  logic           CLK,
  input  logic           RST_N,
  servo_pwm_mc_if.slave  bus
);
  localparam int FRAME_W = $clog2(FRAME_CYC);
  localparam int SLOT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int WDOG_W  = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYC - 1);
  localparam logic [FRAME_W-1:0] FWD_W      = FRAME_W'(FWD_CYC);
  localparam logic [FRAME_W-1:0] NEU_W      = FRAME_W'(NEU_CYC);
  localparam logic [FRAME_W-1:0] REV_W      = FRAME_W'(REV_CYC);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOTS - 1);
  localparam logic [WDOG_W-1:0]  WDOG_MAX   = WDOG_W'(TIMEOUT_FRAMES);

  generate
    if (FWD_CYC >= FRAME_CYC || NEU_CYC >= FRAME_CYC || REV_CYC >= FRAME_CYC) begin : g_bad_widths
      $error("servo_pwm_mc: pulse widths must be shorter than FRAME_CYC");
    end
  endgenerate

  logic [FRAME_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                      frame_start_q, frame_start_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [2*NUM_CH-1:0]       shd_dir_q, shd_dir_d;
  logic [LEVEL_W*NUM_CH-1:0] shd_lvl_q, shd_lvl_d;
  logic [2*NUM_CH-1:0]       act_dir_q, act_dir_d;
  logic [LEVEL_W*NUM_CH-1:0] act_lvl_q, act_lvl_d;
  logic [WDOG_W-1:0]         wdog_cnt_q, wdog_cnt_d;
  logic                      wdog_trip_q, wdog_trip_d;
  logic [NUM_CH-1:0]         pulse_q, pulse_d;

  logic                      wrap;
  logic [FRAME_W-1:0]        width [NUM_CH];

  always_comb begin
    wrap          = (frame_cnt_q == FRAME_LAST);
    frame_cnt_d   = wrap ? '0 : frame_cnt_q + 1'b1;
    frame_start_d = (frame_cnt_q == '0);

    slot_d = slot_q;
    if (wrap) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end

    shd_dir_d = shd_dir_q;
    shd_lvl_d = shd_lvl_q;
    if (bus.Cmd_Valid) begin
      shd_dir_d = bus.Cmd_Dir;
      shd_lvl_d = bus.Cmd_Level;
    end

    // A strobe landing on the wrap cycle bypasses the shadow so it is not lost for a frame.
    act_dir_d = act_dir_q;
    act_lvl_d = act_lvl_q;
    if (wrap) begin
      act_dir_d = bus.Cmd_Valid ? bus.Cmd_Dir   : shd_dir_q;
      act_lvl_d = bus.Cmd_Valid ? bus.Cmd_Level : shd_lvl_q;
    end

    wdog_cnt_d  = wdog_cnt_q;
    wdog_trip_d = wdog_trip_q;
    if (bus.Cmd_Valid) begin
      wdog_cnt_d  = '0;
      wdog_trip_d = 1'b0;
    end else if (wrap) begin
      if (wdog_cnt_q != WDOG_MAX) begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
      if (wdog_cnt_d == WDOG_MAX) begin
        wdog_trip_d = 1'b1;
      end
    end
  end

  // Level >= SLOTS naturally yields 100% since Slot never reaches SLOTS.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      int lvl;
      lvl       = int'(act_lvl_q[ch*LEVEL_W +: LEVEL_W]);
      width[ch] = NEU_W;
      if (!wdog_trip_q && (int'(slot_q) < lvl)) begin
        case (act_dir_q[ch*2 +: 2])
          2'd0:    width[ch] = FWD_W;
          2'd2:    width[ch] = REV_W;
          default: width[ch] = NEU_W;
        endcase
      end
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pulse_d[ch] = (frame_cnt_q < width[ch]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      slot_q        <= '0;
      shd_dir_q     <= {NUM_CH{2'b01}};
      shd_lvl_q     <= '0;
      act_dir_q     <= {NUM_CH{2'b01}};
      act_lvl_q     <= '0;
      wdog_cnt_q    <= '0;
      wdog_trip_q   <= 1'b1;
      pulse_q       <= '0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      slot_q        <= slot_d;
      shd_dir_q     <= shd_dir_d;
      shd_lvl_q     <= shd_lvl_d;
      act_dir_q     <= act_dir_d;
      act_lvl_q     <= act_lvl_d;
      wdog_cnt_q    <= wdog_cnt_d;
      wdog_trip_q   <= wdog_trip_d;
      pulse_q       <= pulse_d;
    end
  end

  assign bus.Pulse_Out   = pulse_q;
  assign bus.Frame_Start = frame_start_q;
  assign bus.Slot        = slot_q;
  assign bus.Wdog_Trip   = wdog_trip_q;
endmodule

// File: tb/tb_servo_pwm_mc.sv
// Directed bench for servo_pwm_mc with a 100-clock frame and 4 slots.
module tb_servo_pwm_mc;
  logic CLK = 1'b0;
  logic RST_N;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  servo_pwm_mc_if #(.NUM_CH(2), .LEVEL_W(5), .SLOT_W(2)) bus ();

  servo_pwm_mc #(
    .NUM_CH(2), .FRAME_CYC(100), .FWD_CYC(10), .NEU_CYC(15), .REV_CYC(20),
    .SLOTS(4), .LEVEL_W(5), .TIMEOUT_FRAMES(3)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Runs one 100-clock frame from frame_cnt==0, optionally strobing a command at index stb.
  task automatic check_frame(input string tag, input int stb, input logic [3:0] dir,
                             input logic [9:0] lvl, input int e0, input int e1,
                             input int etrip, input int eslot);
    int hi0, hi1, trip1, fs_n, fs_pos, slot_mid;
    hi0 = 0; hi1 = 0; trip1 = 0; fs_n = 0; fs_pos = -1; slot_mid = -1;
    for (int i = 0; i < 100; i++) begin
      hi0   += int'(bus.Pulse_Out[0]);
      hi1   += int'(bus.Pulse_Out[1]);
      trip1 += int'(bus.Wdog_Trip);
      if (bus.Frame_Start) begin
        fs_n++;
        fs_pos = i;
      end
      if (i == 50) slot_mid = int'(bus.Slot);
      if (i == stb) begin
        bus.Cmd_Dir   = dir;
        bus.Cmd_Level = lvl;
        bus.Cmd_Valid = 1'b1;
      end else begin
        bus.Cmd_Valid = 1'b0;
      end
      nxt();
    end
    bus.Cmd_Valid = 1'b0;
    chk({tag, "_w0"}, hi0, e0);
    chk({tag, "_w1"}, hi1, e1);
    chk({tag, "_trip"}, trip1, etrip);
    chk({tag, "_slot"}, slot_mid, eslot);
    chk({tag, "_fs_n"}, fs_n, 1);
    chk({tag, "_fs_pos"}, fs_pos, 1);
  endtask

  initial begin
    RST_N         = 1'b0;
    bus.Cmd_Dir   = 4'b0101;
    bus.Cmd_Level = '0;
    bus.Cmd_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_pulse", int'(bus.Pulse_Out), 0);
    chk("rst_fs", int'(bus.Frame_Start), 0);
    chk("rst_slot", int'(bus.Slot), 0);
    chk("rst_trip", int'(bus.Wdog_Trip), 1);
    RST_N = 1'b1;

    // Idle after reset: tripped, neutral on both pins, slot walks 0..3,0.
    check_frame("idle0", -1, 4'h0, 10'h0, 15, 15, 100, 0);
    check_frame("idle1", -1, 4'h0, 10'h0, 15, 15, 100, 1);
    check_frame("idle2", -1, 4'h0, 10'h0, 15, 15, 100, 2);
    check_frame("idle3", -1, 4'h0, 10'h0, 15, 15, 100, 3);
    check_frame("idle4", -1, 4'h0, 10'h0, 15, 15, 100, 0);

    // Mid-frame command: current frame untouched, next frame fwd/rev.
    check_frame("mid_a", 40, {2'd2, 2'd0}, {5'd4, 5'd4}, 15, 15, 41, 1);
    check_frame("mid_b", -1, 4'h0, 10'h0, 10, 20, 0, 2);

    // ch0 rev at level 1, ch1 rev at level 0; refreshed every frame to feed the watchdog.
    check_frame("lv_a", 10, {2'd2, 2'd2}, {5'd0, 5'd1}, 10, 20, 0, 3);
    check_frame("lv_s0", 10, {2'd2, 2'd2}, {5'd0, 5'd1}, 20, 15, 0, 0);
    check_frame("lv_s1", 10, {2'd2, 2'd2}, {5'd0, 5'd1}, 15, 15, 0, 1);
    check_frame("lv_s2", 10, {2'd2, 2'd2}, {5'd0, 5'd1}, 15, 15, 0, 2);
    check_frame("lv_s3", 10, {2'd2, 2'd2}, {5'd0, 5'd1}, 15, 15, 0, 3);
    check_frame("lv_s0b", 10, {2'd2, 2'd2}, {5'd0, 5'd1}, 20, 15, 0, 0);

    // Strobe on the wrap cycle: ch0 fwd level 4, ch1 rev level 3.
    check_frame("byp_a", 99, {2'd2, 2'd0}, {5'd3, 5'd4}, 15, 15, 0, 1);
    check_frame("byp_b", -1, 4'h0, 10'h0, 10, 20, 0, 2);
    check_frame("byp_c", -1, 4'h0, 10'h0, 10, 15, 0, 3);

    // No further strobes: third wrap trips the watchdog.
    check_frame("wd_a", -1, 4'h0, 10'h0, 10, 20, 0, 0);
    check_frame("wd_trip", -1, 4'h0, 10'h0, 15, 15, 100, 1);
    check_frame("wd_rec", 50, {2'd2, 2'd0}, {5'd4, 5'd4}, 15, 15, 51, 2);
    check_frame("wd_ok", -1, 4'h0, 10'h0, 10, 20, 0, 3);

    // Reset pulled mid-pulse at frame_cnt=5.
    repeat (5) nxt();
    chk("pre_rst_pulse", int'(bus.Pulse_Out), 3);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_pulse", int'(bus.Pulse_Out), 0);
    chk("arst_trip", int'(bus.Wdog_Trip), 1);
    chk("arst_slot", int'(bus.Slot), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    check_frame("post0", -1, 4'h0, 10'h0, 15, 15, 100, 0);
    check_frame("post1", -1, 4'h0, 10'h0, 15, 15, 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/servo_pwm_mc.md
Name: servo_pwm_mc

Overview:
- Multi-channel successor to the single-channel power-modulation pulse-width selector.
- Drives the actual RC servo/ESC pulse pins for N channels directly, instead of only producing a pulse-width value.
- Per channel: frame-skipping power control (active frames out of SLOTS), frame-aligned glitch-free command update, and a command watchdog that forces neutral.
- Sits between the navigation controller and the motor ESC pins.

Parameters:
NUM_CH, 2, number of independent output channels
FRAME_CYC, 2000000, clocks per servo frame (20 ms at 100 MHz)
FWD_CYC, 100000, forward pulse width in clocks (1 ms)
NEU_CYC, 150000, neutral pulse width in clocks (1.5 ms)
REV_CYC, 200000, reverse pulse width in clocks (2 ms)
SLOTS, 24, frames per power-modulation cycle
LEVEL_W, 5, width of per-channel level field
TIMEOUT_FRAMES, 50, frames without Cmd_Valid before watchdog trips

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
Cmd_Dir  in  2*NUM_CH  per channel {ch*2+1:ch*2}: 0=fwd, 1=neutral, 2=rev, 3=neutral
Cmd_Level  in  LEVEL_W*NUM_CH  per channel active-frame count per SLOTS
Cmd_Valid  in  1  single-cycle strobe that captures all channel commands
Pulse_Out  out  NUM_CH  servo pulse pins, registered
Frame_Start  out  1  one-cycle strobe at frame_cnt==0
Slot  out  clog2(SLOTS)  current slot index
Wdog_Trip  out  1  high while watchdog forces neutral

Behaviour:
- Reset (async, RST_N low):
  - frame_cnt=0, Slot=0, Pulse_Out=0, Frame_Start=0.
  - Shadow and active commands = {dir 1, level 0}.
  - Wdog_Trip=1; wdog_cnt=0.
- Frame counter:
  - frame_cnt counts 0..FRAME_CYC-1 and wraps.
  - Width is clog2(FRAME_CYC), 21 bits at default.
  - Frame_Start is registered: high in the cycle after frame_cnt becomes 0.
- Slot counter:
  - Increments on the frame_cnt wrap edge, 0..SLOTS-1, then wraps to 0.
- Shadow registers:
  - Cmd_Valid loads the shadow from Cmd_Dir/Cmd_Level on the next edge.
  - Cmd_Valid outside the wrap cycle never alters the active command mid-frame.
- Active load:
  - Happens on the frame_cnt wrap edge only.
  - If Cmd_Valid is asserted on that same cycle, active takes the Cmd inputs directly (bypass); otherwise active takes the shadow.
- Per-channel width, evaluated combinationally from active, Slot and Wdog_Trip:
  - Wdog_Trip=1 -> NEU_CYC.
  - Else dir 0 -> FWD_CYC; dir 2 -> REV_CYC; dir 1 or 3 -> NEU_CYC.
  - A non-neutral width applies only when Slot < level; otherwise NEU_CYC.
  - level >= SLOTS -> always on (100%); level 0 -> always neutral.
- Pulse_Out[ch] <= (frame_cnt < width[ch]).
  - Registered, so it lags frame_cnt by 1 cycle.
  - High for exactly width clocks per frame.
  - Neutral still emits 1.5 ms pulses (ESC arming/hold).
- Watchdog:
  - wdog_cnt increments on each frame wrap and saturates at TIMEOUT_FRAMES.
  - Cmd_Valid clears wdog_cnt to 0 and clears Wdog_Trip on the next edge; Cmd_Valid has priority if simultaneous with a wrap.
  - Wdog_Trip sets on the wrap where wdog_cnt reaches TIMEOUT_FRAMES.
  - When Wdog_Trip sets, the shadow and active commands are left unchanged; only the output is forced to neutral.
  - Trip takes effect from the frame starting at that wrap.
- Reset mid-frame: all outputs drop to 0 immediately; after release, a fresh frame starts at frame_cnt=0.
- Parameter constraint: FWD_CYC, NEU_CYC, REV_CYC < FRAME_CYC. Synthesis assertion required.

Test Plan:
Sim parameters for all scenarios: FRAME_CYC=100, FWD=10, NEU=15, REV=20, SLOTS=4, TIMEOUT_FRAMES=3, NUM_CH=2.
1. Reset release, no commands -> both Pulse_Out high 15 clocks per 100-clock frame; Wdog_Trip=1 throughout; Slot sequence 0,1,2,3,0.
2. Cmd_Valid with ch0 {dir 0, level 4}, ch1 {dir 2, level 4} at frame_cnt=40 -> rest of current frame unchanged (15-clk pulses); next frame ch0=10 clk, ch1=20 clk; Wdog_Trip clears the cycle after the strobe.
3. ch0 {dir 2, level 1} -> 20-clk pulse only in slot 0, 15-clk pulses in slots 1-3, repeating every 400 clocks; level 0 gives 15 clocks in every slot.
4. Cmd_Valid asserted exactly on the frame_cnt=99 cycle with dir 0, level 4 -> the new 10-clk width applies in the immediately following frame (bypass path).
5. Valid command, then no further strobes -> after 3 frame wraps Wdog_Trip=1 and both channels emit 15-clk pulses; a new Cmd_Valid restores the commanded width from the next frame.
6. RST_N pulled low at frame_cnt=5 with Pulse_Out high -> Pulse_Out=0 asynchronously; after release, outputs are neutral and the counters restart from 0.
